// File: rtl/tea_decryptor.sv
// ---------------------------------------------------------------------------
// tea_decryptor
//   Streaming TEA block decryptor. One 64-bit ciphertext block is accepted on
//   the AXI-Stream slave. It is decrypted with one Feistel round per clock over
//   32 rounds, and the plaintext is returned on the AXI-Stream master.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_key[127:0]    k0=[127:96] k1=[95:64] k2=[63:32] k3=[31:0], latched on accept
//   i_axis_valid_s  ciphertext valid
//   o_axis_ready_s  ready for ciphertext (IDLE only)
//   i_axis_data_s   ciphertext, v0=[63:32] v1=[31:0]
//   o_axis_valid_m  plaintext valid (DONE only)
//   i_axis_ready_m  downstream ready
//   o_axis_data_m   plaintext, v0=[63:32] v1=[31:0]; holds last result
// ---------------------------------------------------------------------------
module tea_decryptor #(
    parameter int unsigned NUM_ROUNDS = 32,
    parameter logic [31:0] DELTA      = 32'h9E3779B9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_axis_valid_s,
    output logic         o_axis_ready_s,
    input  logic [63:0]  i_axis_data_s,
    output logic         o_axis_valid_m,
    input  logic         i_axis_ready_m,
    output logic [63:0]  o_axis_data_m
);

    // Decryption starts from the sum value that encryption ends with.
    localparam logic [31:0] SUM_INIT   = 32'(DELTA * NUM_ROUNDS);
    localparam logic [4:0]  LAST_ROUND = 5'(NUM_ROUNDS - 1);

    // Names and encoding are kept stable so the existing formal properties still bind.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOADING    = 2'b01,
        PROCESSING = 2'b10,
        DONE       = 2'b11
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [4:0]   round_counter;

    logic [31:0]  r_v0;
    logic [31:0]  r_v1;
    logic [31:0]  r_sum;
    logic [127:0] r_key;
    logic [63:0]  r_data_m;

    logic [31:0]  w_k0;
    logic [31:0]  w_k1;
    logic [31:0]  w_k2;
    logic [31:0]  w_k3;
    logic [31:0]  w_v1_new;
    logic [31:0]  w_v0_new;
    logic         w_accept;
    logic         w_last_round;

    assign w_k0 = r_key[127:96];
    assign w_k1 = r_key[95:64];
    assign w_k2 = r_key[63:32];
    assign w_k3 = r_key[31:0];

    // One inverse round: v1 is undone first, and the new v1 then feeds the v0 update.
    assign w_v1_new = r_v1 - (((r_v0 << 4) + w_k2) ^ (r_v0 + r_sum) ^ ((r_v0 >> 5) + w_k3));
    assign w_v0_new = r_v0 - (((w_v1_new << 4) + w_k0) ^ (w_v1_new + r_sum)
                              ^ ((w_v1_new >> 5) + w_k1));

    assign w_accept      = i_axis_valid_s && o_axis_ready_s;
    assign w_last_round  = (round_counter == LAST_ROUND);
    assign o_axis_data_m = r_data_m;

    // ----------------------------------------------------------------------
    // FSM: state register
    // ----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ----------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ----------------------------------------------------------------------
    always_comb begin
        next_state     = state;
        // ready is also gated by reset so that a block offered during reset is dropped
        o_axis_ready_s = (state == IDLE) && !i_rst;
        o_axis_valid_m = (state == DONE);
        case (state)
            IDLE:       if (w_accept) next_state = LOADING;
            LOADING:    next_state = PROCESSING;
            PROCESSING: if (w_last_round) next_state = DONE;
            DONE:       if (i_axis_ready_m) next_state = IDLE;
        endcase
    end

    // ----------------------------------------------------------------------
    // Datapath
    // ----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            round_counter <= '0;
            r_v0          <= '0;
            r_v1          <= '0;
            r_sum         <= '0;
            r_key         <= '0;
            r_data_m      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_accept) begin
                        r_v0  <= i_axis_data_s[63:32];
                        r_v1  <= i_axis_data_s[31:0];
                        r_key <= i_key;
                    end
                end
                LOADING: begin
                    r_sum         <= SUM_INIT;
                    round_counter <= '0;
                end
                PROCESSING: begin
                    r_v0          <= w_v0_new;
                    r_v1          <= w_v1_new;
                    r_sum         <= r_sum - DELTA;
                    round_counter <= round_counter + 5'd1;
                    if (w_last_round) begin
                        r_data_m <= {w_v0_new, w_v1_new};
                    end
                end
                DONE: begin
                    // r_data_m holds until the next block completes
                end
            endcase
        end
    end

endmodule
